// File: rtl/cpu_mem_responder.sv
// CPU memory responder: 2 KB mirrored work RAM plus a PRG ROM image loaded over a byte stream.
// Define PRG_MIRROR16K_EN for a 16 KB image mirrored across $8000-$FFFF; default is a 32 KB image.
module cpu_mem_responder (
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic [15:0] Addr_bus,
  input  logic        RW,
  input  logic [7:0]  Wr_data,
  output logic [7:0]  Data_bus,
  output logic        cpu_hold,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  input  logic        ld_restart,
  output logic        ld_done
);

  localparam int unsigned RAM_AW    = 11;
  localparam int unsigned RAM_DEPTH = 1 << RAM_AW;
  localparam int unsigned PTR_W     = 15;
`ifdef PRG_MIRROR16K_EN
  localparam int unsigned ROM_AW    = 14;
`else
  localparam int unsigned ROM_AW    = 15;
`endif
  localparam int unsigned ROM_DEPTH = 1 << ROM_AW;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(ROM_DEPTH - 1);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               ld_ready_d;
  logic               cpu_hold_d;
  logic               ld_done_d;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   ptr_d;
  logic               load_we;
  logic               run;
  logic               ram_sel;
  logic               rom_sel;
  logic               ram_we;
  logic               rd_en;
  logic [7:0]         rd_data_c;
  logic [7:0]         ram_mem [RAM_DEPTH];
  logic [7:0]         rom_mem [ROM_DEPTH];

`ifdef PRG_MIRROR16K_EN
  // Address bit 14 is a don't-care in the mirrored 16 KB map.
  logic unused_addr;
  assign unused_addr = Addr_bus[14];
`endif

  // State and registered status outputs
  always_ff @(posedge clk_ph1 or negedge rst) begin
    if (!rst) begin
      state_q  <= S_LOAD;
      ld_ready <= 1'b1;
      cpu_hold <= 1'b1;
      ld_done  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ld_ready <= ld_ready_d;
      cpu_hold <= cpu_hold_d;
      ld_done  <= ld_done_d;
    end
  end

  // Next-state: restart always wins; the last image byte completes the load
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD: begin
        if (!ld_restart && ld_valid && (ptr_q == LAST_PTR)) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (ld_restart) begin
          state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Status outputs decoded from the next state so they change on the transition edge
  always_comb begin
    ld_ready_d = 1'b1;
    cpu_hold_d = 1'b1;
    ld_done_d  = 1'b0;
    if (state_d == S_RUN) begin
      ld_ready_d = 1'b0;
      cpu_hold_d = 1'b0;
      ld_done_d  = 1'b1;
    end
  end

  // Load pointer
  assign load_we = (state_q == S_LOAD) && ld_valid && !ld_restart;

  always_comb begin
    ptr_d = ptr_q;
    if (ld_restart) begin
      ptr_d = '0;
    end else if (load_we) begin
      ptr_d = (ptr_q == LAST_PTR) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_ph1 or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // CPU address decode: RAM at $0000-$1FFF, ROM at $8000-$FFFF, open bus between
  assign run     = (state_q == S_RUN);
  assign ram_sel = (Addr_bus[15:13] == 3'b000);
  assign rom_sel = Addr_bus[15];
  assign ram_we  = run && !RW && ram_sel;
  assign rd_en   = run && RW && (ram_sel || rom_sel);

  // Storage arrays are not reset; contents survive reset and restart
  always_ff @(posedge clk_ph1) begin
    if (ram_we) begin
      ram_mem[Addr_bus[RAM_AW-1:0]] <= Wr_data;
    end
  end

  always_ff @(posedge clk_ph1) begin
    if (load_we) begin
      rom_mem[ptr_q[ROM_AW-1:0]] <= ld_data;
    end
  end

  assign rd_data_c = ram_sel ? ram_mem[Addr_bus[RAM_AW-1:0]]
                             : rom_mem[Addr_bus[ROM_AW-1:0]];

  // Read data holds on writes, open-bus reads and while loading
  always_ff @(posedge clk_ph1 or negedge rst) begin
    if (!rst) begin
      Data_bus <= 8'h00;
    end else if (rd_en) begin
      Data_bus <= rd_data_c;
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: load sequencing, reset/restart, RAM mirror, ROM map, open bus.
module tb_cpu_mem_responder;

`ifdef PRG_MIRROR16K_EN
  localparam int LEN = 16384;
`else
  localparam int LEN = 32768;
`endif

  logic        clk_ph1;
  logic        rst;
  logic [15:0] Addr_bus;
  logic        RW;
  logic [7:0]  Wr_data;
  logic [7:0]  Data_bus;
  logic        cpu_hold;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        ld_restart;
  logic        ld_done;

  int checks = 0;
  int errors = 0;

  cpu_mem_responder dut (
    .clk_ph1    (clk_ph1),
    .rst        (rst),
    .Addr_bus   (Addr_bus),
    .RW         (RW),
    .Wr_data    (Wr_data),
    .Data_bus   (Data_bus),
    .cpu_hold   (cpu_hold),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .ld_restart (ld_restart),
    .ld_done    (ld_done)
  );

  initial clk_ph1 = 1'b0;
  always #5 clk_ph1 = ~clk_ph1;

  task automatic step;
    @(posedge clk_ph1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_rd(input logic [15:0] addr);
    Addr_bus = addr;
    RW       = 1'b1;
    step();
  endtask

  task automatic cpu_wr(input logic [15:0] addr, input logic [7:0] data);
    Addr_bus = addr;
    Wr_data  = data;
    RW       = 1'b0;
    step();
  endtask

  // Stream a full image (byte = ptr[7:0], optionally inverted) with an idle gap mid-stream
  task automatic load_image(input logic inv);
    for (int i = 0; i < LEN; i++) begin
      ld_valid = 1'b1;
      ld_data  = inv ? ~8'(i) : 8'(i);
      if (i == LEN - 1) chk("done_before_last_byte", 16'(ld_done), 16'h0);
      step();
      if (i == 5000) begin
        ld_valid = 1'b0;
        ld_data  = 8'hEE;
        step();
        step();
      end
    end
    ld_valid = 1'b0;
    chk("ld_done_after_load", 16'(ld_done), 16'h1);
    chk("ld_ready_after_load", 16'(ld_ready), 16'h0);
    chk("cpu_hold_after_load", 16'(cpu_hold), 16'h0);
  endtask

  initial begin
    rst        = 1'b0;
    Addr_bus   = 16'h8000;
    RW         = 1'b1;
    Wr_data    = 8'h00;
    ld_valid   = 1'b0;
    ld_data    = 8'h00;
    ld_restart = 1'b0;

    #12;
    chk("rst_ld_ready", 16'(ld_ready), 16'h1);
    chk("rst_cpu_hold", 16'(cpu_hold), 16'h1);
    chk("rst_ld_done", 16'(ld_done), 16'h0);
    chk("rst_data_bus", 16'(Data_bus), 16'h00);
    rst = 1'b1;
    step();

    // Partial load of 100 bytes while the CPU tries to read ROM
    for (int i = 0; i < 100; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'h33;
      step();
    end
    ld_valid = 1'b0;
    chk("load_read_ignored", 16'(Data_bus), 16'h00);
    chk("partial_ld_ready", 16'(ld_ready), 16'h1);

    // Reset mid-load
    rst = 1'b0;
    #2;
    chk("midrst_ld_ready", 16'(ld_ready), 16'h1);
    chk("midrst_ld_done", 16'(ld_done), 16'h0);
    rst = 1'b1;
    step();

    // Restart together with a byte: the byte must be dropped
    ld_restart = 1'b1;
    ld_valid   = 1'b1;
    ld_data    = 8'hEE;
    step();
    ld_restart = 1'b0;
    ld_valid   = 1'b0;
    chk("restart_ld_ready", 16'(ld_ready), 16'h1);

    load_image(1'b0);

    // ROM map
    cpu_rd(16'hFFFC);
    chk("rd_FFFC", 16'(Data_bus), 16'h00FC);
`ifdef PRG_MIRROR16K_EN
    cpu_rd(16'hBFFC);
    chk("rd_BFFC", 16'(Data_bus), 16'h00FC);
`endif
    cpu_rd(16'h8123);
    chk("rd_8123", 16'(Data_bus), 16'h0023);
    cpu_rd(16'h8000);
    chk("rd_8000", 16'(Data_bus), 16'h0000);

    // RAM and its mirrors
    cpu_wr(16'h0123, 8'hA5);
    chk("wr_holds_bus", 16'(Data_bus), 16'h0000);
    cpu_rd(16'h1923);
    chk("rd_1923_mirror", 16'(Data_bus), 16'h00A5);
    cpu_wr(16'h07FF, 8'h3C);
    cpu_rd(16'h1FFF);
    chk("rd_1FFF_mirror", 16'(Data_bus), 16'h003C);
    cpu_wr(16'h0010, 8'h12);
    cpu_rd(16'h0810);
    chk("rd_0810_mirror", 16'(Data_bus), 16'h0012);

    // Open bus and ROM write protection
    cpu_rd(16'h8001);
    chk("rd_8001", 16'(Data_bus), 16'h0001);
    cpu_rd(16'h4016);
    chk("open_bus_4016", 16'(Data_bus), 16'h0001);
    cpu_rd(16'h2000);
    chk("open_bus_2000", 16'(Data_bus), 16'h0001);
    cpu_rd(16'h7FFF);
    chk("open_bus_7FFF", 16'(Data_bus), 16'h0001);
    cpu_wr(16'h8001, 8'h55);
    chk("rom_wr_holds_bus", 16'(Data_bus), 16'h0001);
    cpu_rd(16'h0123);
    chk("rd_0123", 16'(Data_bus), 16'h00A5);
    cpu_rd(16'h8001);
    chk("rom_wr_ignored", 16'(Data_bus), 16'h0001);

    // Restart from RUN; CPU accesses are ignored while loading
    Addr_bus   = 16'h4000;
    RW         = 1'b1;
    ld_restart = 1'b1;
    step();
    ld_restart = 1'b0;
    chk("run_restart_cpu_hold", 16'(cpu_hold), 16'h1);
    chk("run_restart_ld_ready", 16'(ld_ready), 16'h1);
    chk("run_restart_ld_done", 16'(ld_done), 16'h0);
    cpu_wr(16'h0010, 8'h77);
    chk("load_wr_holds_bus", 16'(Data_bus), 16'h0001);
    cpu_rd(16'h0010);
    chk("load_rd_holds_bus", 16'(Data_bus), 16'h0001);

    // Reload with an inverted pattern; RAM survives, ROM is overwritten
    load_image(1'b1);
    cpu_rd(16'h0010);
    chk("ram_0010_unchanged", 16'(Data_bus), 16'h0012);
    cpu_rd(16'hFFFC);
    chk("reload_rd_FFFC", 16'(Data_bus), 16'h0003);
    cpu_rd(16'h8123);
    chk("reload_rd_8123", 16'(Data_bus), 16'h00DC);
    cpu_rd(16'h1923);
    chk("ram_0123_retained", 16'(Data_bus), 16'h00A5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 The block SHALL have these ports, in order: clk_ph1  in  1  single clock, all state updates on rising edge.
REQ-002 The block SHALL have the port rst  in  1  reset, asynchronous, active-low.
REQ-003 The block SHALL have the port Addr_bus  in  16  CPU address, sampled every clk_ph1 edge.
REQ-004 The block SHALL have the port RW  in  1  access direction, 1=read, 0=write.
REQ-005 The block SHALL have the port Wr_data  in  8  CPU write data, sampled with Addr_bus when RW=0.
REQ-006 The block SHALL have the port Data_bus  out  8  registered read data returned to the CPU.
REQ-007 The block SHALL have the port cpu_hold  out  1  1 while the PRG image is not loaded; the CPU must be held off.
REQ-008 The block SHALL have the ports ld_valid  in  1  and ld_data  in  8, forming the PRG load byte stream.
REQ-009 The block SHALL have the port ld_ready  out  1  1 while the block accepts load bytes.
REQ-010 The block SHALL have the port ld_restart  in  1  single-cycle pulse that restarts the image load.
REQ-011 The block SHALL have the port ld_done  out  1  1 when the full image is loaded.

Function
REQ-012 The block SHALL contain 2048x8 work RAM and a PRG ROM store of 32768x8, or 16384x8 when the macro in REQ-027 is defined.
REQ-013 The block SHALL implement a state machine with two states: LOAD (ld_ready=1, cpu_hold=1, ld_done=0) and RUN (ld_ready=0, cpu_hold=0, ld_done=1).
REQ-014 In LOAD, each cycle with ld_valid=1 SHALL write ld_data to ROM[ptr] and increment the 15-bit pointer ptr; when ld_valid=0, ptr SHALL be held.
REQ-015 The byte written at ptr=LEN-1 SHALL cause a transition to RUN on the same edge, with ptr wrapping to 0; LEN is 32768, or 16384 with the macro.
REQ-016 In RUN, ld_valid SHALL be ignored; an ld_restart pulse SHALL return the block to LOAD with ptr=0, and ROM contents SHALL be retained until overwritten.
REQ-017 An ld_restart pulse in LOAD SHALL reset ptr to 0 and take priority over a simultaneous ld_valid byte, which SHALL be dropped.
REQ-018 In RUN, a read (RW=1) SHALL update Data_bus on the following clk_ph1 edge, giving one-cycle latency, according to REQ-019 to REQ-021.
REQ-019 Reads of $0000-$1FFF SHALL return RAM[Addr_bus[10:0]], so the RAM is mirrored four times.
REQ-020 Reads of $8000-$FFFF SHALL return ROM[Addr_bus[14:0]], or ROM[Addr_bus[13:0]] with the macro.
REQ-021 Reads of $2000-$7FFF are open bus and SHALL leave Data_bus at its previous value.
REQ-022 In RUN, a write (RW=0) to $0000-$1FFF SHALL store Wr_data at RAM[Addr_bus[10:0]]; writes to any other address SHALL be ignored, and Data_bus SHALL hold on every write cycle.
REQ-023 In LOAD, CPU reads and writes SHALL be ignored: RAM is unchanged and Data_bus holds.
REQ-024 A read from a RAM address that is being written in the same cycle is not possible on this single-port bus, so no bypass is required.

Reset
REQ-025 On rst=0, asynchronously: state=LOAD, ptr=0, Data_bus=8'h00, ld_ready=1, cpu_hold=1, ld_done=0.
REQ-026 RAM and ROM contents SHALL NOT be cleared by reset; a reset in the middle of a load SHALL restart the load from ptr=0.

Configuration
REQ-027 The macro PRG_MIRROR16K_EN SHALL select the image size. When defined: 16 KB ROM, LEN=16384, and $C000-$FFFF mirrors $8000-$BFFF. When undefined: 32 KB ROM, LEN=32768, with no mirroring.

Verification
REQ-028 Reset, then stream LEN bytes with value = ptr[7:0] -> ld_done rises on the edge of the final byte, ld_ready=0, and cpu_hold=0.
REQ-029 After load, read $FFFC -> Data_bus=8'hFC one cycle later; with the macro, read $BFFC -> 8'hFC and $FFFC -> 8'hFC.
REQ-030 Write 8'hA5 to $0123, then read $1923 -> Data_bus=8'hA5 (mirror).
REQ-031 Read $8001 (Data_bus=8'h01), then read $4016 -> Data_bus stays 8'h01; write 8'h55 to $8001 -> a later read of $8001 still returns 8'h01.
REQ-032 Midway through a load, assert rst=0 at byte 100 -> ld_ready=1 and ptr=0; then assert ld_restart together with ld_valid -> the byte is dropped and ptr stays 0.
REQ-033 In RUN, pulse ld_restart -> cpu_hold=1, and a CPU write of 8'h77 to $0010 leaves RAM[$0010] unchanged.
